// File: rtl/nrzi_deserialize.sv
// nrzi_deserialize
//   NRZI receive stage: decodes 0..IN_WIDTH line bits per cycle to NRZ
//   (1 = transition) and packs the variable-rate stream into OUT_WIDTH-bit
//   words, oldest bit in the MSB.
//
// Parameters
//   IN_WIDTH    maximum line bits per cycle (1 <= IN_WIDTH <= OUT_WIDTH)
//   OUT_WIDTH   bits per emitted word
//   ACT_TIMEOUT valid bits without a transition before `active` drops
//               (only meaningful with NRZI_ACTIVITY_EN)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   nrzi        line bits, bit IN_WIDTH-1 oldest; valid bits at the top
//   nrzi_valid  number of valid line bits this cycle (clamped to IN_WIDTH)
//   resync      discard buffered bits; this cycle's bits start a new word
//   nrz         decoded word, MSB = oldest bit; holds between strobes
//   nrz_valid   one-cycle strobe marking a new word on `nrz`
//   active      line activity indication
//
// Configuration
//   NRZI_ACTIVITY_EN  when defined, builds the activity counter; otherwise
//                     `active` is tied to 1.

module nrzi_deserialize #(
    parameter int IN_WIDTH    = 2,
    parameter int OUT_WIDTH   = 5,
    parameter int ACT_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           nrzi,
    input  logic [$clog2(IN_WIDTH+1)-1:0] nrzi_valid,
    input  logic                          resync,
    output logic [OUT_WIDTH-1:0]          nrz,
    output logic                          nrz_valid,
    output logic                          active
);

    localparam int FW    = $clog2(OUT_WIDTH + 1);
    localparam int CMB_W = OUT_WIDTH + IN_WIDTH;

    if (IN_WIDTH < 1 || IN_WIDTH > OUT_WIDTH || ACT_TIMEOUT < 1) begin : g_param_check
        $error("nrzi_deserialize: illegal parameter combination");
    end

    logic                 nrzi_last, nrzi_last_n;
    // pack_buf[j] is the j-th oldest buffered decoded bit; bits >= fill are stale.
    logic [OUT_WIDTH-1:0] pack_buf, pack_buf_n;
    logic [FW-1:0]        fill, fill_n;
    logic [OUT_WIDTH-1:0] nrz_n;
    logic                 emit;
    // dec[i] is the i-th oldest decoded bit of this cycle; zero beyond k.
    logic [IN_WIDTH-1:0]  dec;
    logic [CMB_W-1:0]     comb;
    logic                 prev;
    int unsigned          k;
    int unsigned          base;
    int unsigned          total;

    always_comb begin
        k           = (32'(nrzi_valid) > IN_WIDTH) ? IN_WIDTH : 32'(nrzi_valid);
        dec         = '0;
        prev        = nrzi_last;
        nrzi_last_n = nrzi_last;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (i < k) begin
                dec[i]      = nrzi[IN_WIDTH-1-i] ^ prev;
                prev        = nrzi[IN_WIDTH-1-i];
                nrzi_last_n = prev;
            end
        end

        // resync drops the buffered bits, so new bits land at position 0.
        base = resync ? 0 : 32'(fill);
        comb = '0;
        for (int unsigned j = 0; j < OUT_WIDTH; j++) begin
            if (j < base) comb[j] = pack_buf[j];
        end
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (i < k) comb[base+i] = dec[i];
        end
        total = base + k;

        emit       = !resync && (total >= OUT_WIDTH);
        nrz_n      = nrz;
        pack_buf_n = '0;
        if (emit) begin
            for (int unsigned j = 0; j < OUT_WIDTH; j++) begin
                nrz_n[OUT_WIDTH-1-j] = comb[j];
            end
            // Leftover bits (fewer than IN_WIDTH) shift down to the buffer head.
            for (int unsigned j = 0; j < IN_WIDTH; j++) begin
                pack_buf_n[j] = comb[j+OUT_WIDTH];
            end
            fill_n = FW'(total - OUT_WIDTH);
        end else begin
            pack_buf_n = comb[OUT_WIDTH-1:0];
            fill_n     = FW'(total);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nrzi_last <= 1'b0;
            pack_buf  <= '0;
            fill      <= '0;
            nrz       <= '0;
            nrz_valid <= 1'b0;
        end else begin
            nrzi_last <= nrzi_last_n;
            pack_buf  <= pack_buf_n;
            fill      <= fill_n;
            nrz       <= nrz_n;
            nrz_valid <= emit;
        end
    end

`ifdef NRZI_ACTIVITY_EN
    localparam int CW = $clog2(ACT_TIMEOUT + 1);

    logic [CW-1:0] act_cnt, act_cnt_n;
    logic          seen_one, seen_one_n;
    logic          any_one;

    always_comb begin
        any_one    = |dec;
        seen_one_n = seen_one | any_one;
        if (any_one) begin
            act_cnt_n = '0;
        end else if (32'(act_cnt) + k >= ACT_TIMEOUT) begin
            act_cnt_n = CW'(ACT_TIMEOUT);
        end else begin
            act_cnt_n = CW'(32'(act_cnt) + k);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_cnt  <= '0;
            seen_one <= 1'b0;
            active   <= 1'b0;
        end else begin
            act_cnt  <= act_cnt_n;
            seen_one <= seen_one_n;
            active   <= seen_one_n && (32'(act_cnt_n) < ACT_TIMEOUT);
        end
    end
`else
    assign active = 1'b1;
`endif

endmodule

// File: doc/nrzi_deserialize.md
# nrzi_deserialize

Parametrised NRZI receive stage for the 100BASE-X PHY path. It accepts 0..IN_WIDTH NRZI line bits per cycle from the clock-recovery/sampling logic, decodes them to NRZ (1 = transition), and packs the variable-rate bit stream into fixed OUT_WIDTH-bit words for the 4B/5B decoder. It is the multi-bit, word-packing, resettable successor to the 2-bit NRZI decoder.

## Interface

- IN_WIDTH, 2: maximum line bits accepted per cycle; 1 <= IN_WIDTH <= OUT_WIDTH.
- OUT_WIDTH, 5: bits per emitted NRZ word.
- ACT_TIMEOUT, 64: valid bits without a transition before `active` drops. Used only with NRZI_ACTIVITY_EN.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- nrzi  input  IN_WIDTH  line bits, MSB-first: bit IN_WIDTH-1 is oldest; the valid bits occupy the top `nrzi_valid` positions.
- nrzi_valid  input  $clog2(IN_WIDTH+1)  number of valid bits this cycle, k; values > IN_WIDTH are clamped to IN_WIDTH.
- resync  input  1  synchronous word realignment request.
- nrz  output  OUT_WIDTH  decoded word, MSB = oldest bit.
- nrz_valid  output  1  one-cycle strobe: `nrz` holds a new word.
- active  output  1  line activity indication (see Configuration).

## Operation

- State: `nrzi_last` (last valid line bit), packing buffer of OUT_WIDTH+IN_WIDTH-1 bits, fill count 0..OUT_WIDTH-1.
- Decode: for the k valid bits, each decoded bit is its line bit XOR the preceding line bit. The first valid bit uses `nrzi_last`. After the cycle, `nrzi_last` is the newest valid bit; it is unchanged when k = 0.
- Pack: decoded bits append after the buffered bits in arrival order.
  - If fill+k >= OUT_WIDTH, the oldest OUT_WIDTH bits are registered to `nrz` with `nrz_valid` = 1, and fill becomes fill+k-OUT_WIDTH.
  - Otherwise fill becomes fill+k and `nrz_valid` = 0.
- At most one word is emitted per cycle. No overflow is possible by construction.
- `nrz` holds its last value between strobes.
- resync = 1:
  - Buffered bits are discarded. This cycle's k decoded bits become the start of the new word, so fill = k.
  - `nrz_valid` = 0 that cycle. `nrzi_last` updates normally, so decode continuity is kept.
- Simultaneous resync and word completion: resync wins and no word is emitted.
- Undefined line bits below the valid count are ignored and never reach state.

## Timing

- Reset values (asynchronous): nrz = 0, nrz_valid = 0, nrzi_last = 0, fill = 0, activity counter = 0, active = 0 (macro on) / 1 (macro off).
- Latency: a word completed by bits presented in cycle N strobes `nrz_valid` in cycle N+1.
- `active` is registered and updates one cycle after the bits that change it.
- Reset asserted mid-word discards the partial word. The first post-reset bit decodes against `nrzi_last` = 0.
- No combinational path from any input to any output.

## Configuration

- NRZI_ACTIVITY_EN defined:
  - A saturating counter of valid bits since the last decoded 1 is built.
  - Any cycle containing a decoded 1 clears the counter. Otherwise the counter adds k, saturating at ACT_TIMEOUT.
  - `active` = (at least one decoded 1 since reset) AND (counter < ACT_TIMEOUT).
  - resync does not affect the counter.
- NRZI_ACTIVITY_EN undefined: no counter is built, and `active` is the constant 1, including during reset.

## Test plan

All scenarios use IN_WIDTH = 2 and OUT_WIDTH = 5.

- Reset, then nrzi={1,1} k=2, then {0,0} k=2, then {1,x} k=1 -> one strobe the next cycle with nrz = 5'b10101; fill = 0.
- Reset, then nrzi = 1 with k = 1 for 5 cycles -> nrz = 5'b10000 with one strobe; further k = 0 cycles give no strobe and no change to `nrzi_last`.
- Continuous k = 2 for 10 cycles -> strobes after input cycles 3, 5, 8 and 10 (20 bits = 4 words); word boundaries are checked against a bit-serial model.
- resync asserted with fill = 3 and k = 2 in the same cycle -> no strobe; the next word contains those 2 bits first, then the following 3.
- NRZI_ACTIVITY_EN, ACT_TIMEOUT = 64, one transition then a constant line for 64 valid bits -> `active` = 1 from the cycle after the transition; `active` = 0 the cycle after the 64th bit; the next transition re-asserts it.
- rst pulsed mid-word with fill = 4 -> outputs drop to their reset values immediately; the next 5 bits form a fresh word with no residue.
